// File: rtl/slave_rx_fifo.sv
// Receive-side byte FIFO: accepts bytes from master over valid/ready and presents them first-word-fall-through downstream.
// Optional running checksum of accepted bytes is built when SLAVE_RX_CHECKSUM_EN is defined.
module slave_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              checksum
);

    // Handshake: a byte moves on a port in any cycle where its valid and ready are both high at the rising edge.
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign ready     = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    // Flush suppresses both transfers so nothing presented in that cycle survives.
    assign w_push = valid & ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef SLAVE_RX_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (flush) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + {8'd0, data_in[7:0]};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_slave_rx_fifo.sv
// Directed bench for slave_rx_fifo: a vector table for transfer/full behaviour plus hand sequences
// for concurrent push/pop, flush, checksum wrap and asynchronous reset.
module tb_slave_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
`ifdef SLAVE_RX_CHECKSUM_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;
    logic              ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic [15:0]       checksum;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              fl;
        logic              ordy;
        logic              e_rdy;
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vt[20];

    slave_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .ready(ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [7:0] d, logic ordy,
                                logic e_rdy, logic e_ov, logic [7:0] e_od, logic [2:0] e_cnt);
        vec_t r;
        r.v = v; r.d = d; r.fl = 1'b0; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_od = e_od; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic fl, input logic ordy);
        @(negedge clk);
        valid = v; data_in = d; flush = fl; out_ready = ordy;
        #1;
    endtask

    initial begin
        // Transfer and full-condition table; expectations are the state seen before each rising edge.
        vt[0]  = mk(1, 8'h11, 0, 1, 0, 8'h00, 3'd0);
        vt[1]  = mk(1, 8'h22, 0, 1, 1, 8'h11, 3'd1);
        vt[2]  = mk(1, 8'h33, 0, 1, 1, 8'h11, 3'd2);
        vt[3]  = mk(0, 8'h00, 1, 1, 1, 8'h11, 3'd3);
        vt[4]  = mk(0, 8'h00, 1, 1, 1, 8'h22, 3'd2);
        vt[5]  = mk(0, 8'h00, 1, 1, 1, 8'h33, 3'd1);
        vt[6]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 3'd0);
        vt[7]  = mk(1, 8'hA0, 0, 1, 0, 8'h00, 3'd0);
        vt[8]  = mk(1, 8'hA1, 0, 1, 1, 8'hA0, 3'd1);
        vt[9]  = mk(1, 8'hA2, 0, 1, 1, 8'hA0, 3'd2);
        vt[10] = mk(1, 8'hA3, 0, 1, 1, 8'hA0, 3'd3);
        vt[11] = mk(1, 8'hFF, 0, 0, 1, 8'hA0, 3'd4);
        vt[12] = mk(1, 8'hFF, 0, 0, 1, 8'hA0, 3'd4);
        vt[13] = mk(1, 8'hFF, 1, 0, 1, 8'hA0, 3'd4);
        vt[14] = mk(1, 8'hFF, 0, 1, 1, 8'hA1, 3'd3);
        vt[15] = mk(0, 8'h00, 1, 0, 1, 8'hA1, 3'd4);
        vt[16] = mk(0, 8'h00, 1, 1, 1, 8'hA2, 3'd3);
        vt[17] = mk(0, 8'h00, 1, 1, 1, 8'hA3, 3'd2);
        vt[18] = mk(0, 8'h00, 1, 1, 1, 8'hFF, 3'd1);
        vt[19] = mk(0, 8'h00, 0, 1, 0, 8'h00, 3'd0);

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_odata", 32'(out_data), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].v, vt[i].d, vt[i].fl, vt[i].ordy);
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vt[i].e_rdy));
            check($sformatf("vec%0d_ovalid", i), 32'(out_valid), 32'(vt[i].e_ov));
            check($sformatf("vec%0d_odata", i), 32'(out_data), 32'(vt[i].e_od));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
        end
        check("table_checksum", 32'(checksum), CHK_ON ? 32'h03EB : 32'd0);

        // Concurrent push and pop at occupancy 2; pointers wrap repeatedly.
        drive(1, 8'hB0, 0, 0); exp_q.push_back(8'hB0);
        drive(1, 8'hB1, 0, 0); exp_q.push_back(8'hB1);
        for (int k = 0; k < 10; k++) begin
            drive(1, 8'(8'hB2 + k), 0, 1);
            check($sformatf("conc%0d_count", k), 32'(count), 32'd2);
            check($sformatf("conc%0d_odata", k), 32'(out_data), 32'(exp_q.pop_front()));
            exp_q.push_back(8'(8'hB2 + k));
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 8'h00, 0, 1);
            check($sformatf("drain%0d_odata", k), 32'(out_data), 32'(exp_q.pop_front()));
        end
        drive(0, 8'h00, 0, 0);
        check("conc_empty_count", 32'(count), 32'd0);
        check("conc_checksum", 32'(checksum), CHK_ON ? 32'h0C6D : 32'd0);

        // Flush with a simultaneous push and pop: both are discarded.
        drive(1, 8'hC0, 0, 0);
        drive(1, 8'hC1, 0, 0);
        drive(1, 8'hC2, 0, 0);
        drive(1, 8'hDD, 1, 1);
        check("preflush_count", 32'(count), 32'd3);
        drive(0, 8'h00, 0, 0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_ovalid", 32'(out_valid), 32'd0);
        check("flush_odata", 32'(out_data), 32'd0);
        check("flush_checksum", 32'(checksum), 32'd0);
        check("flush_ready", 32'(ready), 32'd1);
        drive(1, 8'hE5, 0, 0);
        check("postflush_count", 32'(count), 32'd0);
        drive(0, 8'h00, 0, 0);
        check("postflush_odata", 32'(out_data), 32'hE5);
        check("postflush_cnt1", 32'(count), 32'd1);
        check("postflush_checksum", 32'(checksum), CHK_ON ? 32'h00E5 : 32'd0);

        // 300 pushes of 0xFF: 76500 mod 65536 = 10964.
        drive(0, 8'h00, 1, 0);
        for (int k = 0; k < 300; k++) begin
            drive(1, 8'hFF, 0, 1);
        end
        drive(0, 8'h00, 0, 1);
        check("sum300_count", 32'(count), 32'd1);
        check("sum300_checksum", 32'(checksum), CHK_ON ? 32'd10964 : 32'd0);
        drive(0, 8'h00, 0, 0);

        // Asynchronous reset between clock edges with data in flight.
        drive(1, 8'h42, 0, 0);
        drive(1, 8'h43, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("prearst_count", 32'(count), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_ovalid", 32'(out_valid), 32'd0);
        check("arst_checksum", 32'(checksum), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 8'h00, 0, 0);
        check("postarst_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
